// File: rtl/fft_bram_port_arbiter.sv
// Shares the single sample BRAM port between the stream load/unload engine (R0) and the
// butterfly engine (R1): round-robin grants, RMW locking, registered access, tagged read return.
module fft_bram_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_r0_req,
    input  logic              i_r0_we,
    input  logic              i_r0_lock,
    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [DATA_W-1:0] i_r0_din,
    output logic              o_r0_gnt,
    output logic              o_r0_rvalid,
    output logic [DATA_W-1:0] o_r0_rdata,
    input  logic              i_r1_req,
    input  logic              i_r1_we,
    input  logic              i_r1_lock,
    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic [DATA_W-1:0] i_r1_din,
    output logic              o_r1_gnt,
    output logic              o_r1_rvalid,
    output logic [DATA_W-1:0] o_r1_rdata,
    output logic              o_bram_we,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [DATA_W-1:0] o_bram_din,
    input  logic [DATA_W-1:0] i_bram_dout,
    output logic [15:0]       o_stat_conflicts
);
    typedef enum logic [1:0] {LOCK_NONE, LOCK_R0, LOCK_R1} lock_t;

    // One tag stage per cycle between grant and read data: the register stage plus the BRAM latency.
    localparam int TAG_DEPTH = RD_LAT + 1;

    lock_t               r_lockOwn;
    lock_t               w_lockNext;
    logic                r_lastGnt;
    logic                r_bramWe;
    logic [ADDR_W-1:0]   r_bramAddr;
    logic [DATA_W-1:0]   r_bramDin;
    logic [TAG_DEPTH-1:0] r_tagValid;
    logic [TAG_DEPTH-1:0] r_tagId;
    logic [15:0]         r_stat;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_xfer;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_din;
    logic                w_conflict;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lockOwn <= LOCK_NONE;
        end else begin
            r_lockOwn <= w_lockNext;
        end
    end

    // Only the requester that actually transfers can move the lock; an idle owner keeps it.
    always_comb begin
        w_lockNext = r_lockOwn;
        if (w_gnt0) begin
            w_lockNext = i_r0_lock ? LOCK_R0 : LOCK_NONE;
        end else if (w_gnt1) begin
            w_lockNext = i_r1_lock ? LOCK_R1 : LOCK_NONE;
        end
    end

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_lockOwn)
            LOCK_R0: w_gnt0 = i_r0_req;
            LOCK_R1: w_gnt1 = i_r1_req;
            default: begin
                if (i_r0_req && i_r1_req) begin
                    w_gnt0 = r_lastGnt;
                    w_gnt1 = ~r_lastGnt;
                end else begin
                    w_gnt0 = i_r0_req;
                    w_gnt1 = i_r1_req;
                end
            end
        endcase
    end

    assign w_xfer     = w_gnt0 | w_gnt1;
    assign w_we       = w_gnt1 ? i_r1_we   : i_r0_we;
    assign w_addr     = w_gnt1 ? i_r1_addr : i_r0_addr;
    assign w_din      = w_gnt1 ? i_r1_din  : i_r0_din;
    assign w_conflict = (i_r0_req & ~w_gnt0) | (i_r1_req & ~w_gnt1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lastGnt  <= 1'b1;
            r_bramWe   <= 1'b0;
            r_bramAddr <= '0;
            r_bramDin  <= '0;
            r_tagValid <= '0;
            r_tagId    <= '0;
            r_stat     <= '0;
        end else begin
            r_bramWe   <= w_xfer & w_we;
            r_tagValid <= {r_tagValid[TAG_DEPTH-2:0], w_xfer & ~w_we};
            r_tagId    <= {r_tagId[TAG_DEPTH-2:0], w_gnt1};
            if (w_xfer) begin
                r_lastGnt  <= w_gnt1;
                r_bramAddr <= w_addr;
                r_bramDin  <= w_din;
            end
            if (w_conflict && (r_stat != 16'hFFFF)) begin
                r_stat <= r_stat + 16'd1;
            end
        end
    end

    assign o_r0_gnt         = w_gnt0;
    assign o_r1_gnt         = w_gnt1;
    assign o_r0_rvalid      = r_tagValid[RD_LAT] & ~r_tagId[RD_LAT];
    assign o_r1_rvalid      = r_tagValid[RD_LAT] & r_tagId[RD_LAT];
    assign o_r0_rdata       = i_bram_dout;
    assign o_r1_rdata       = i_bram_dout;
    assign o_bram_we        = r_bramWe;
    assign o_bram_addr      = r_bramAddr;
    assign o_bram_din       = r_bramDin;
    assign o_stat_conflicts = r_stat;
endmodule

// File: tb/tb_fft_bram_port_arbiter.sv
// Directed bench for fft_bram_port_arbiter: an RD_LAT=1 instance checked in detail and an
// RD_LAT=2 instance sharing its inputs, each with its own behavioural BRAM.
module tb_fft_bram_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;

    typedef struct {
        logic          req0, we0, lock0;
        logic [AW-1:0] addr0;
        logic [DW-1:0] din0;
        logic          req1, we1, lock1;
        logic [AW-1:0] addr1;
        logic [DW-1:0] din1;
        logic          gnt0, gnt1, bwe;
        logic [AW-1:0] baddr;
        logic          rv0, rv1;
        logic [DW-1:0] rdata;
        logic [15:0]   stat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0Req, r0We, r0Lock, r1Req, r1We, r1Lock;
    logic [AW-1:0] r0Addr, r1Addr;
    logic [DW-1:0] r0Din, r1Din;

    logic          r0Gnt, r0Rvalid, r1Gnt, r1Rvalid, bramWe;
    logic [DW-1:0] r0Rdata, r1Rdata, bramDin, bramDout;
    logic [AW-1:0] bramAddr;
    logic [15:0]   statConflicts;

    logic          r0GntB, r0RvalidB, r1GntB, r1RvalidB, bramWeB;
    logic [DW-1:0] r0RdataB, r1RdataB, bramDinB, bramDoutB;
    logic [AW-1:0] bramAddrB;
    logic [15:0]   statConflictsB;

    logic [DW-1:0] memA [0:255];
    logic [DW-1:0] memB [0:255];
    logic [DW-1:0] memBStage;

    int vectorCount = 0;
    int missCount   = 0;
    vec_t vecs [15];

    always #5 clk = ~clk;

    fft_bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_r0_req(r0Req), .i_r0_we(r0We), .i_r0_lock(r0Lock), .i_r0_addr(r0Addr), .i_r0_din(r0Din),
        .o_r0_gnt(r0Gnt), .o_r0_rvalid(r0Rvalid), .o_r0_rdata(r0Rdata),
        .i_r1_req(r1Req), .i_r1_we(r1We), .i_r1_lock(r1Lock), .i_r1_addr(r1Addr), .i_r1_din(r1Din),
        .o_r1_gnt(r1Gnt), .o_r1_rvalid(r1Rvalid), .o_r1_rdata(r1Rdata),
        .o_bram_we(bramWe), .o_bram_addr(bramAddr), .o_bram_din(bramDin), .i_bram_dout(bramDout),
        .o_stat_conflicts(statConflicts)
    );

    fft_bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dutLat2 (
        .i_clk(clk), .i_rst(rst),
        .i_r0_req(r0Req), .i_r0_we(r0We), .i_r0_lock(r0Lock), .i_r0_addr(r0Addr), .i_r0_din(r0Din),
        .o_r0_gnt(r0GntB), .o_r0_rvalid(r0RvalidB), .o_r0_rdata(r0RdataB),
        .i_r1_req(r1Req), .i_r1_we(r1We), .i_r1_lock(r1Lock), .i_r1_addr(r1Addr), .i_r1_din(r1Din),
        .o_r1_gnt(r1GntB), .o_r1_rvalid(r1RvalidB), .o_r1_rdata(r1RdataB),
        .o_bram_we(bramWeB), .o_bram_addr(bramAddrB), .o_bram_din(bramDinB), .i_bram_dout(bramDoutB),
        .o_stat_conflicts(statConflictsB)
    );

    // Behavioural BRAMs: one-cycle and two-cycle read latency from the registered address.
    always @(posedge clk) begin
        if (bramWe) memA[bramAddr[7:0]] <= bramDin;
        bramDout <= memA[bramAddr[7:0]];
    end

    always @(posedge clk) begin
        if (bramWeB) memB[bramAddrB[7:0]] <= bramDinB;
        memBStage <= memB[bramAddrB[7:0]];
        bramDoutB <= memBStage;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic q0, input logic w0, input logic l0,
                                 input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic q1, input logic w1, input logic l1,
                                 input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        r0Req = q0; r0We = w0; r0Lock = l0; r0Addr = a0; r0Din = d0;
        r1Req = q1; r1We = w1; r1Lock = l1; r1Addr = a1; r1Din = d1;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleInputs();
        nextCycle();
        rst = 1'b0;
    endtask

    initial begin
        //         r0: req   we    lock  addr      din             r1: req   we    lock  addr      din
        //         exp: gnt0 gnt1  bwe   baddr     rv0   rv1   rdata           stat
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 14'h10, 32'hA1B2C3D4, 1'b0, 1'b0, 1'b0, 14'h00, 32'h0,
                     1'b1, 1'b0, 1'b0, 14'h00, 1'b0, 1'b0, 32'h0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 14'h10, 32'h0, 1'b0, 1'b0, 1'b0, 14'h00, 32'h0,
                     1'b1, 1'b0, 1'b1, 14'h10, 1'b0, 1'b0, 32'h0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 14'h00, 32'h0, 1'b0, 1'b0, 1'b0, 14'h00, 32'h0,
                     1'b0, 1'b0, 1'b0, 14'h10, 1'b0, 1'b0, 32'h0, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 14'h00, 32'h0, 1'b0, 1'b0, 1'b0, 14'h00, 32'h0,
                     1'b0, 1'b0, 1'b0, 14'h10, 1'b1, 1'b0, 32'hA1B2C3D4, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 14'h00, 32'h0, 1'b1, 1'b1, 1'b0, 14'h20, 32'h11112222,
                     1'b0, 1'b1, 1'b0, 14'h10, 1'b0, 1'b0, 32'h0, 16'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 14'h20, 32'h0, 1'b1, 1'b0, 1'b0, 14'h10, 32'h0,
                     1'b1, 1'b0, 1'b1, 14'h20, 1'b0, 1'b0, 32'h0, 16'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 14'h10, 32'h0, 1'b1, 1'b0, 1'b0, 14'h10, 32'h0,
                     1'b0, 1'b1, 1'b0, 14'h20, 1'b0, 1'b0, 32'h0, 16'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 14'h00, 32'h0, 1'b0, 1'b0, 1'b0, 14'h00, 32'h0,
                     1'b0, 1'b0, 1'b0, 14'h10, 1'b1, 1'b0, 32'h11112222, 16'd2};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 14'h00, 32'h0, 1'b0, 1'b0, 1'b0, 14'h00, 32'h0,
                     1'b0, 1'b0, 1'b0, 14'h10, 1'b0, 1'b1, 32'hA1B2C3D4, 16'd2};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 14'h20, 32'h0, 1'b1, 1'b1, 1'b0, 14'h30, 32'h33334444,
                     1'b1, 1'b0, 1'b0, 14'h10, 1'b0, 1'b0, 32'h0, 16'd2};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 14'h00, 32'h0, 1'b1, 1'b1, 1'b0, 14'h30, 32'h33334444,
                     1'b0, 1'b0, 1'b0, 14'h20, 1'b0, 1'b0, 32'h0, 16'd3};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 14'h40, 32'h55, 1'b1, 1'b1, 1'b0, 14'h30, 32'h33334444,
                     1'b1, 1'b0, 1'b0, 14'h20, 1'b1, 1'b0, 32'h11112222, 16'd4};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 14'h00, 32'h0, 1'b1, 1'b1, 1'b0, 14'h30, 32'h33334444,
                     1'b0, 1'b1, 1'b1, 14'h40, 1'b0, 1'b0, 32'h0, 16'd5};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 14'h00, 32'h0, 1'b0, 1'b0, 1'b0, 14'h00, 32'h0,
                     1'b0, 1'b0, 1'b1, 14'h30, 1'b0, 1'b0, 32'h0, 16'd5};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 14'h00, 32'h0, 1'b0, 1'b0, 1'b0, 14'h00, 32'h0,
                     1'b0, 1'b0, 1'b0, 14'h30, 1'b0, 1'b0, 32'h0, 16'd5};

        doReset();

        // Reset values as seen in the first cycle after reset.
        @(negedge clk);
        checkOutput("reset bram_we", 32'(bramWe), 32'd0);
        checkOutput("reset bram_addr", 32'(bramAddr), 32'd0);
        checkOutput("reset bram_din", bramDin, 32'd0);
        checkOutput("reset r0_rvalid", 32'(r0Rvalid), 32'd0);
        checkOutput("reset r1_rvalid", 32'(r1Rvalid), 32'd0);
        checkOutput("reset stat", 32'(statConflicts), 32'd0);
        nextCycle();

        // Table-driven single accesses, ties, and an R0 lock/unlock.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].req0, vecs[i].we0, vecs[i].lock0, vecs[i].addr0, vecs[i].din0,
                          vecs[i].req1, vecs[i].we1, vecs[i].lock1, vecs[i].addr1, vecs[i].din1);
            @(negedge clk);
            checkOutput($sformatf("v%0d r0_gnt", i), 32'(r0Gnt), 32'(vecs[i].gnt0));
            checkOutput($sformatf("v%0d r1_gnt", i), 32'(r1Gnt), 32'(vecs[i].gnt1));
            checkOutput($sformatf("v%0d bram_we", i), 32'(bramWe), 32'(vecs[i].bwe));
            checkOutput($sformatf("v%0d bram_addr", i), 32'(bramAddr), 32'(vecs[i].baddr));
            checkOutput($sformatf("v%0d r0_rvalid", i), 32'(r0Rvalid), 32'(vecs[i].rv0));
            checkOutput($sformatf("v%0d r1_rvalid", i), 32'(r1Rvalid), 32'(vecs[i].rv1));
            checkOutput($sformatf("v%0d stat", i), 32'(statConflicts), 32'(vecs[i].stat));
            if (vecs[i].rv0) checkOutput($sformatf("v%0d r0_rdata", i), r0Rdata, vecs[i].rdata);
            if (vecs[i].rv1) checkOutput($sformatf("v%0d r1_rdata", i), r1Rdata, vecs[i].rdata);
            nextCycle();
        end

        // Both requesters reading continuously for 8 cycles.
        doReset();
        for (int c = 0; c < 10; c++) begin
            logic expRv0, expRv1;
            if (c < 8) applyStimulus(1'b1, 1'b0, 1'b0, 14'h10, 32'h0, 1'b1, 1'b0, 1'b0, 14'h20, 32'h0);
            else       idleInputs();
            expRv0 = (c >= 2) && (c - 2 < 8) && ((c - 2) % 2 == 0);
            expRv1 = (c >= 3) && (c - 2 < 8) && ((c - 2) % 2 == 1);
            @(negedge clk);
            if (c < 8) begin
                checkOutput($sformatf("rr c%0d r0_gnt", c), 32'(r0Gnt), 32'(c % 2 == 0));
                checkOutput($sformatf("rr c%0d r1_gnt", c), 32'(r1Gnt), 32'(c % 2 == 1));
            end
            checkOutput($sformatf("rr c%0d r0_rvalid", c), 32'(r0Rvalid), 32'(expRv0));
            checkOutput($sformatf("rr c%0d r1_rvalid", c), 32'(r1Rvalid), 32'(expRv1));
            if (expRv0) checkOutput($sformatf("rr c%0d r0_rdata", c), r0Rdata, 32'hA1B2C3D4);
            if (expRv1) checkOutput($sformatf("rr c%0d r1_rdata", c), r1Rdata, 32'h11112222);
            if (c >= 8) checkOutput($sformatf("rr c%0d stat", c), 32'(statConflicts), 32'd8);
            nextCycle();
        end

        // R1 locks with a read, idles three cycles, then unlocks with a write; R0 waits throughout.
        doReset();
        for (int c = 0; c < 9; c++) begin
            logic q0, w0, q1, w1, l1;
            logic [AW-1:0] a1;
            logic [DW-1:0] d0, d1;
            q0 = (c <= 6); w0 = (c == 0); d0 = (c == 0) ? 32'h66 : 32'h0;
            q1 = (c == 1) || (c == 5); w1 = (c == 5); l1 = (c == 1);
            a1 = (c == 1) ? 14'h20 : 14'h60;
            d1 = (c == 5) ? 32'h77 : 32'h0;
            applyStimulus(q0, w0, 1'b0, 14'h50, d0, q1, w1, l1, a1, d1);
            @(negedge clk);
            checkOutput($sformatf("lock c%0d r0_gnt", c), 32'(r0Gnt), 32'((c == 0) || (c == 6)));
            checkOutput($sformatf("lock c%0d r1_gnt", c), 32'(r1Gnt), 32'((c == 1) || (c == 5)));
            checkOutput($sformatf("lock c%0d r1_rvalid", c), 32'(r1Rvalid), 32'(c == 3));
            checkOutput($sformatf("lock c%0d r0_rvalid", c), 32'(r0Rvalid), 32'(c == 8));
            if (c == 3) checkOutput("lock r1_rdata", r1Rdata, 32'h11112222);
            if (c == 8) checkOutput("lock r0_rdata", r0Rdata, 32'h66);
            if (c == 7) checkOutput("lock stat", 32'(statConflicts), 32'd5);
            nextCycle();
        end

        // Reset right after two read grants discards them and restores the tie order.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 14'h10, 32'h0, 1'b1, 1'b0, 1'b0, 14'h20, 32'h0);
        @(negedge clk);
        checkOutput("rstmid c0 r0_gnt", 32'(r0Gnt), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("rstmid c1 r1_gnt", 32'(r1Gnt), 32'd1);
        nextCycle();
        rst = 1'b1;
        idleInputs();
        @(negedge clk);
        checkOutput("rstmid stat before", 32'(statConflicts), 32'd2);
        nextCycle();
        rst = 1'b0;
        for (int c = 3; c < 6; c++) begin
            if (c == 3) applyStimulus(1'b1, 1'b1, 1'b0, 14'h10, 32'hA1B2C3D4, 1'b1, 1'b1, 1'b0, 14'h70, 32'h88);
            else        idleInputs();
            @(negedge clk);
            if (c == 3) begin
                checkOutput("rstmid tie r0_gnt", 32'(r0Gnt), 32'd1);
                checkOutput("rstmid tie r1_gnt", 32'(r1Gnt), 32'd0);
                checkOutput("rstmid bram_we", 32'(bramWe), 32'd0);
                checkOutput("rstmid stat after", 32'(statConflicts), 32'd0);
            end
            if (c == 5) checkOutput("rstmid stat restart", 32'(statConflicts), 32'd1);
            checkOutput($sformatf("rstmid c%0d r0_rvalid", c), 32'(r0Rvalid), 32'd0);
            checkOutput($sformatf("rstmid c%0d r1_rvalid", c), 32'(r1Rvalid), 32'd0);
            nextCycle();
        end

        // Write 1..4 to addr 0..3, read 3..0 back-to-back on both latency builds.
        doReset();
        for (int c = 0; c < 12; c++) begin
            logic expA, expB;
            if (c < 4)      applyStimulus(1'b1, 1'b1, 1'b0, 14'(c), 32'(c + 1), 1'b0, 1'b0, 1'b0, '0, '0);
            else if (c < 8) applyStimulus(1'b1, 1'b0, 1'b0, 14'(7 - c), 32'h0, 1'b0, 1'b0, 1'b0, '0, '0);
            else            idleInputs();
            expA = (c >= 6) && (c <= 9);
            expB = (c >= 7) && (c <= 10);
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                checkOutput($sformatf("seq c%0d bram_we", c), 32'(bramWe), 32'd1);
                checkOutput($sformatf("seq c%0d bram_addr", c), 32'(bramAddr), 32'(c - 1));
                checkOutput($sformatf("seq c%0d bram_din", c), bramDin, 32'(c));
            end
            if (c >= 4) begin
                checkOutput($sformatf("seq c%0d lat1 rvalid", c), 32'(r0Rvalid), 32'(expA));
                checkOutput($sformatf("seq c%0d lat2 rvalid", c), 32'(r0RvalidB), 32'(expB));
                checkOutput($sformatf("seq c%0d lat1 r1_rvalid", c), 32'(r1Rvalid), 32'd0);
            end
            if (expA) checkOutput($sformatf("seq c%0d lat1 rdata", c), r0Rdata, 32'(10 - c));
            if (expB) checkOutput($sformatf("seq c%0d lat2 rdata", c), r0RdataB, 32'(11 - c));
            nextCycle();
        end

        // Conflict counter saturation under a long continuous tie.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 14'h10, 32'h0, 1'b1, 1'b0, 1'b0, 14'h20, 32'h0);
        for (int n = 0; n < 70000; n++) begin
            @(negedge clk);
            if (n == 65534) checkOutput("sat 65534", 32'(statConflicts), 32'h0000FFFE);
            if (n == 65535) checkOutput("sat 65535", 32'(statConflicts), 32'h0000FFFF);
            if (n == 69999) checkOutput("sat 69999", 32'(statConflicts), 32'h0000FFFF);
            nextCycle();
        end
        idleInputs();
        @(negedge clk);
        checkOutput("sat hold", 32'(statConflicts), 32'h0000FFFF);
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
